shift4_ser_ctrl: RTL and testbench

//  Sequencer for the Shift4 right-shift register. Accepts parallel words over a valid/ready port and loads each one into the register.

---
 rtl/shift4_ser_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_shift4_ser_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shift4_ser_ctrl.sv
// ---------------------------------------------------------------------------
// shift4_ser_ctrl
//
// Sequencer that sits between a parallel word producer and an external
// Shift4 right-shift register. A word accepted on the in_* valid/ready port
// is captured into sh_data and loaded into the shift register with a single
// sh_load pulse. The controller then presents sh_q[0] as a serial bit on the
// ser_* valid/ready port and pulses sh_ena on every completed serial
// handshake, so the word leaves LSB-first. An optional idle gap follows the
// last bit of each word before a new word is accepted.
//
// Parameters
//   size : word width, must match the Shift4 instance (>= 2)
//   gap  : idle cycles after the last bit before in_ready rises (0..255)
//
// Ports
//   clk        in   clock, rising edge
//   areset     in   synchronous active-high reset
//   in_valid   in   parallel word available
//   in_ready   out  controller can accept a word (IDLE only)
//   in_data    in   parallel word
//   sh_load    out  load strobe to Shift4 (one cycle per word)
//   sh_ena     out  shift strobe to Shift4 (one per serial handshake)
//   sh_data    out  registered copy of the accepted word, to Shift4 data
//   sh_q       in   Shift4 register contents
//   ser_valid  out  serial bit valid
//   ser_ready  in   serial consumer takes the bit
//   ser_bit    out  current serial bit (sh_q[0])
//   ser_last   out  current bit is the final bit of the word
//   busy       out  controller is not idle
// ---------------------------------------------------------------------------
module shift4_ser_ctrl #(
    parameter int size = 4,
    parameter int gap  = 0
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] in_data,
    output logic            sh_load,
    output logic            sh_ena,
    output logic [size-1:0] sh_data,
    input  logic [size-1:0] sh_q,
    output logic            ser_valid,
    input  logic            ser_ready,
    output logic            ser_bit,
    output logic            ser_last,
    output logic            busy
);

    localparam int              CNT_W      = (size > 1) ? $clog2(size) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(size - 1);
    localparam bit              HAS_GAP    = (gap > 0);
    // Gap counter is loaded with gap-1 so that GAP lasts exactly gap cycles.
    localparam logic [7:0]      GAP_RELOAD = (gap > 0) ? 8'(gap - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [7:0]       gap_q,     gap_d;
    logic [size-1:0]  sh_data_q, sh_data_d;

    logic             first_bit_s;

    // Next-state, bit/gap counter and word-capture logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        sh_data_d = sh_data_q;
        case (state_q)
            ST_IDLE: begin
                // in_ready is 1 in IDLE, so in_valid alone completes the handshake.
                if (in_valid) begin
                    sh_data_d = in_data;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = ST_LOAD;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    if (cnt_q != LAST_IDX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = {CNT_W{1'b0}};
                        if (HAS_GAP) begin
                            gap_d   = GAP_RELOAD;
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    // Stall: sh_q is not shifted, so ser_bit stays stable.
                    state_d = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                gap_d   = 8'd0;
            end
        endcase
    end

    // State and datapath registers; reset takes priority over any transition.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            gap_q     <= 8'd0;
            sh_data_q <= {size{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            sh_data_q <= sh_data_d;
        end
    end

    // Output decode. Every output is forced low while areset is asserted so
    // that neither port sees a handshake during a reset cycle.
    always_comb begin
        in_ready  = 1'b0;
        sh_load   = 1'b0;
        sh_ena    = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        sh_data   = {size{1'b0}};
        if (areset) begin
            busy = 1'b0;
        end else begin
            sh_data = sh_data_q;
            case (state_q)
                ST_IDLE: begin
                    in_ready = 1'b1;
                end
                ST_LOAD: begin
                    sh_load = 1'b1;
                    busy    = 1'b1;
                end
                ST_SHIFT: begin
                    ser_valid = 1'b1;
                    ser_bit   = sh_q[0];
                    ser_last  = (cnt_q == LAST_IDX);
                    // Shift at the same edge that completes the serial handshake.
                    sh_ena    = ser_ready;
                    busy      = 1'b1;
                end
                ST_GAP: begin
                    busy = 1'b1;
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end
    end

    assign first_bit_s = (state_q == ST_SHIFT) && (cnt_q == {CNT_W{1'b0}});

    shift4_ser_ctrl_chk #(
        .size (size)
    ) u_chk (
        .clk       (clk),
        .areset    (areset),
        .in_ready  (in_ready),
        .sh_load   (sh_load),
        .sh_ena    (sh_ena),
        .ser_valid (ser_valid),
        .busy      (busy),
        .first_bit (first_bit_s),
        .sh_data   (sh_data),
        .sh_q      (sh_q)
    );

endmodule

// ---------------------------------------------------------------------------
// shift4_ser_ctrl_chk
//
// Protocol properties of shift4_ser_ctrl. Not part of the datapath.
//
// Ports
//   clk, areset : clock and reset of the controller
//   in_ready, sh_load, sh_ena, ser_valid, busy : controller outputs
//   first_bit   : controller is presenting bit 0 of a word
//   sh_data     : word handed to the shift register
//   sh_q        : shift register contents
// ---------------------------------------------------------------------------
module shift4_ser_ctrl_chk #(
    parameter int size = 4
) (
    input logic            clk,
    input logic            areset,
    input logic            in_ready,
    input logic            sh_load,
    input logic            sh_ena,
    input logic            ser_valid,
    input logic            busy,
    input logic            first_bit,
    input logic [size-1:0] sh_data,
    input logic [size-1:0] sh_q
);

    // Load and shift strobes are mutually exclusive.
    a_load_ena_excl : assert property (@(posedge clk) !(sh_load && sh_ena));

    // A shift only happens while a serial bit is offered.
    a_ena_needs_valid : assert property (@(posedge clk) sh_ena |-> ser_valid);

    // Words are only accepted while idle.
    a_ready_idle : assert property (@(posedge clk) in_ready |-> !busy);

    // The shift register must hold the loaded word when bit 0 is presented.
    a_loaded_word : assert property (@(posedge clk) disable iff (areset)
                                     first_bit |-> (sh_q == sh_data));

endmodule

// File: tb/tb_shift4_ser_ctrl.sv
module tb_shift4_ser_ctrl;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       ser_ready = 1'b1;

    // gap = 0 instance
    logic       o0_in_ready, o0_sh_load, o0_sh_ena, o0_ser_valid, o0_ser_bit, o0_ser_last, o0_busy;
    logic [3:0] o0_sh_data;
    logic [3:0] q0 = 4'd0;
    // gap = 2 instance
    logic       o2_in_ready, o2_sh_load, o2_sh_ena, o2_ser_valid, o2_ser_bit, o2_ser_last, o2_busy;
    logic [3:0] o2_sh_data;
    logic [3:0] q2 = 4'd0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift4_ser_ctrl #(.size(4), .gap(0)) u_dut0 (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(o0_in_ready),
        .in_data(in_data), .sh_load(o0_sh_load), .sh_ena(o0_sh_ena), .sh_data(o0_sh_data),
        .sh_q(q0), .ser_valid(o0_ser_valid), .ser_ready(ser_ready), .ser_bit(o0_ser_bit),
        .ser_last(o0_ser_last), .busy(o0_busy)
    );

    shift4_ser_ctrl #(.size(4), .gap(2)) u_dut2 (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(o2_in_ready),
        .in_data(in_data), .sh_load(o2_sh_load), .sh_ena(o2_sh_ena), .sh_data(o2_sh_data),
        .sh_q(q2), .ser_valid(o2_ser_valid), .ser_ready(ser_ready), .ser_bit(o2_ser_bit),
        .ser_last(o2_ser_last), .busy(o2_busy)
    );

    // Shift4 models: load, else shift right with zero fill; not cleared by areset.
    always @(posedge clk) begin
        if (o0_sh_load) q0 <= o0_sh_data;
        else if (o0_sh_ena) q0 <= {1'b0, q0[3:1]};
        if (o2_sh_load) q2 <= o2_sh_data;
        else if (o2_sh_ena) q2 <= {1'b0, q2[3:1]};
    end

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] data;
        logic       rdy;
        logic [6:0] exp; // {in_ready, sh_load, sh_ena, ser_valid, ser_bit, ser_last, busy}
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Apply inputs 1 time unit after a rising edge, leave time to settle.
    task automatic drive(input logic r, input logic v, input logic [3:0] d, input logic rd);
        @(posedge clk);
        #1;
        areset = r; in_valid = v; in_data = d; ser_ready = rd;
        #2;
    endtask

    function automatic logic [6:0] outs0();
        return {o0_in_ready, o0_sh_load, o0_sh_ena, o0_ser_valid, o0_ser_bit, o0_ser_last, o0_busy};
    endfunction

    logic [7:0]  stream;
    logic [11:0] ir_tr;
    logic [8:0]  ir2_tr, busy2_tr, last2_tr;
    int          nbits, nload;

    initial begin
        // Test 1: reset then word 1011 with ser_ready held high
        vecs[0]  = '{1'b1, 1'b0, 4'h0,    1'b1, 7'b0000000};
        vecs[1]  = '{1'b1, 1'b1, 4'h0,    1'b1, 7'b0000000};
        vecs[2]  = '{1'b0, 1'b1, 4'b1011, 1'b1, 7'b1000000};
        vecs[3]  = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0100001};
        vecs[4]  = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0011101};
        vecs[5]  = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0011101};
        vecs[6]  = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0011001};
        vecs[7]  = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0011111};
        vecs[8]  = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b1000000};
        // Test 2: word 0110 with backpressure 1,0,0,1,1,0,1
        vecs[9]  = '{1'b0, 1'b1, 4'b0110, 1'b1, 7'b1000000};
        vecs[10] = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0100001};
        vecs[11] = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0011001};
        vecs[12] = '{1'b0, 1'b0, 4'h0,    1'b0, 7'b0001101};
        vecs[13] = '{1'b0, 1'b0, 4'h0,    1'b0, 7'b0001101};
        vecs[14] = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0011101};
        vecs[15] = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0011101};
        vecs[16] = '{1'b0, 1'b0, 4'h0,    1'b0, 7'b0001011};
        vecs[17] = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b0011011};
        vecs[18] = '{1'b0, 1'b0, 4'h0,    1'b1, 7'b1000000};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].rdy);
            chk($sformatf("vec%0d", i), 32'(outs0()), 32'(vecs[i].exp));
        end

        // Test 3: back-to-back A then 5 with in_valid held
        stream = 8'd0; ir_tr = 12'd0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, (i == 0) ? 4'hA : 4'h5, 1'b1);
            ir_tr = {ir_tr[10:0], o0_in_ready};
            if (o0_ser_valid && ser_ready) stream = {stream[6:0], o0_ser_bit};
        end
        chk("b2b_stream", 32'(stream), 32'h5A);
        chk("b2b_in_ready", 32'(ir_tr), 32'(12'b100000100000));
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        chk("b2b_idle", 32'(outs0()), 32'(7'b1000000));

        // Test 4: gap=2 instance, word F
        drive(1'b1, 1'b0, 4'h0, 1'b1);
        drive(1'b1, 1'b0, 4'h0, 1'b1);
        stream = 8'd0; nbits = 0; ir2_tr = 9'd0; busy2_tr = 9'd0; last2_tr = 9'd0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, (i == 0), 4'hF, 1'b1);
            ir2_tr   = {ir2_tr[7:0], o2_in_ready};
            busy2_tr = {busy2_tr[7:0], o2_busy};
            last2_tr = {last2_tr[7:0], o2_ser_last};
            if (o2_ser_valid && ser_ready) begin
                stream = {stream[6:0], o2_ser_bit};
                nbits++;
            end
        end
        chk("gap_in_ready", 32'(ir2_tr), 32'(9'b100000001));
        chk("gap_busy", 32'(busy2_tr), 32'(9'b011111110));
        chk("gap_last", 32'(last2_tr), 32'(9'b000001000));
        chk("gap_bits", 32'(stream[3:0]), 32'hF);
        chk("gap_nbits", 32'(nbits), 32'd4);

        // Test 5: reset after 2 of 4 bits of 1100, then word 0011
        drive(1'b0, 1'b1, 4'b1100, 1'b1);
        chk("rst_accept", 32'(outs0()), 32'(7'b1000000));
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        chk("rst_bit0", 32'(outs0()), 32'(7'b0011001));
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        drive(1'b1, 1'b0, 4'h0, 1'b1);
        chk("rst_cycle", 32'(outs0()), 32'(7'b0000000));
        chk("rst_sh_data", 32'(o0_sh_data), 32'h0);
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        chk("rst_after", 32'(outs0()), 32'(7'b1000000));
        drive(1'b0, 1'b1, 4'b0011, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        stream = 8'd0; nbits = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 4'h0, 1'b1);
            if (o0_ser_valid && ser_ready) begin
                stream = {stream[6:0], o0_ser_bit};
                nbits++;
            end
        end
        chk("rst_sh_data_word", 32'(o0_sh_data), 32'h3);
        chk("rst_stream", 32'(stream[3:0]), 32'(4'b1100));
        chk("rst_nbits", 32'(nbits), 32'd4);

        // Test 6: in_valid held and in_data toggling while busy
        drive(1'b0, 1'b1, 4'b1101, 1'b1);
        stream = 8'd0; nbits = 0; nload = 0; ir_tr = 12'd0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 1) ? 4'h0 : 4'hF, 1'b1);
            ir_tr = {ir_tr[10:0], o0_in_ready};
            if (o0_sh_load) nload++;
            if (o0_ser_valid && ser_ready) begin
                stream = {stream[6:0], o0_ser_bit};
                nbits++;
            end
        end
        chk("hold_in_ready", 32'(ir_tr[4:0]), 32'h0);
        chk("hold_nload", 32'(nload), 32'd1);
        chk("hold_sh_data", 32'(o0_sh_data), 32'(4'b1101));
        chk("hold_stream", 32'(stream[3:0]), 32'(4'b1011));
        chk("hold_nbits", 32'(nbits), 32'd4);
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        chk("hold_idle", 32'(outs0()), 32'(7'b1000000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
